pkt_gen_ext: RTL and testbench

PKT_GEN_EXT -- requirements
Module: pkt_gen_ext

---
 rtl/pkt_gen_pkg.sv | 30 +++
 rtl/pkt_gen_seq_tbl.sv | 31 +++
 rtl/pkt_gen_ext.sv | 181 ++++++++++++++++++
 tb/tb_pkt_gen_ext.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_gen_pkg.sv
// Shared types and helpers for the packet generator.
// Holds the FSM state enum, header field positions, and the size-to-beats helper.
package pkt_gen_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  localparam int unsigned SIZE_W = 16;
  localparam int unsigned SEQ_W  = 32;
  localparam int unsigned CNT_W  = 32;

  // Header layout on beat 0: size, per-flow sequence, zero-extended flow
  localparam int unsigned HDR_SIZE_LSB = 0;
  localparam int unsigned HDR_SEQ_LSB  = 16;
  localparam int unsigned HDR_FLOW_LSB = 48;
  localparam int unsigned HDR_FLOW_W   = 16;

  localparam int unsigned SUM_W = SIZE_W + 1;

  // ceil(size / 2**lg_bpw); one extra bit keeps size=65535 plus rounding from wrapping
  function automatic logic [SIZE_W-1:0] words_from_size(input logic [SIZE_W-1:0] size,
                                                        input int unsigned       lg_bpw);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(size) + (SUM_W'(1) << lg_bpw) - SUM_W'(1);
    return SIZE_W'(sum >> lg_bpw);
  endfunction

endpackage

// File: rtl/pkt_gen_seq_tbl.sv
// Per-flow 32-bit sequence number table.
// Ports: clk_i/rst_i (async, active-high), rd_flow_i -> rd_seq_c (combinational read),
//        inc_i/inc_flow_i increments the addressed entry modulo 2^32.
module pkt_gen_seq_tbl
  import pkt_gen_pkg::*;
#(
  parameter int unsigned FLOW_CNT = 16,
  parameter int unsigned FLOW_W   = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [FLOW_W-1:0] rd_flow_i,
  output logic [SEQ_W-1:0]  rd_seq_c,
  input  logic              inc_i,
  input  logic [FLOW_W-1:0] inc_flow_i
);

  logic [SEQ_W-1:0] seq_q [FLOW_CNT];

  // Sequence storage; increments on end-of-packet of the given flow
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(FLOW_CNT); i++) seq_q[i] <= '0;
    end else if (inc_i) begin
      seq_q[inc_flow_i] <= seq_q[inc_flow_i] + SEQ_W'(1);
    end
  end

  assign rd_seq_c = seq_q[rd_flow_i];

endmodule

// File: rtl/pkt_gen_ext.sv
// Packet generator: accepts (flow, size) tasks and streams header + counting-byte payload.
// Ports: clk_i/rst_i (async, active-high); task_* request handshake (task_ready_o is
//        combinational from out_ready_i to allow back-to-back packets); out_* beat stream
//        with sop/eop/empty and valid/ready; out_flow_num_o flow of current packet;
//        pkt_cnt_o count of completed packets.
module pkt_gen_ext
  import pkt_gen_pkg::*;
#(
  parameter int unsigned FLOW_CNT       = 16,
  parameter int unsigned FLOW_CNT_WIDTH = (FLOW_CNT == 1) ? 1 : $clog2(FLOW_CNT),
  parameter int unsigned BYTES_PER_WORD = 8,
  parameter int unsigned DATA_W         = 8 * BYTES_PER_WORD,
  parameter int unsigned EMPTY_W        = $clog2(BYTES_PER_WORD)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [FLOW_CNT_WIDTH-1:0] task_flow_num_i,
  input  logic [SIZE_W-1:0]         task_size_i,
  input  logic                      task_valid_i,
  output logic                      task_ready_o,
  output logic [DATA_W-1:0]         out_data_o,
  output logic                      out_sop_o,
  output logic                      out_eop_o,
  output logic [EMPTY_W-1:0]        out_empty_o,
  output logic                      out_val_o,
  input  logic                      out_ready_i,
  output logic [FLOW_CNT_WIDTH-1:0] out_flow_num_o,
  output logic [CNT_W-1:0]          pkt_cnt_o
);

  state_e                    state_q, state_d;
  logic [SIZE_W-1:0]         size_q, size_d;
  logic [SIZE_W-1:0]         words_q, words_d;
  logic [SIZE_W-1:0]         beat_q, beat_d;
  logic [FLOW_CNT_WIDTH-1:0] flow_d;
  logic [DATA_W-1:0]         data_d;
  logic [EMPTY_W-1:0]        empty_d;
  logic                      val_d, sop_d, eop_d;
  logic                      ready_arm_q;
  logic                      load;

  logic                      xfer, xfer_eop, accept_pkt;
  logic [SEQ_W-1:0]          tbl_seq, hdr_seq;
  logic [SIZE_W-1:0]         words_new, beat_nxt;

  function automatic logic [EMPTY_W-1:0] empty_of(input logic [SIZE_W-1:0] size);
    return EMPTY_W'(BYTES_PER_WORD - int'(size[EMPTY_W-1:0]));
  endfunction

  function automatic logic [DATA_W-1:0] header(input logic [FLOW_CNT_WIDTH-1:0] flow,
                                               input logic [SIZE_W-1:0]         size,
                                               input logic [SEQ_W-1:0]          seq);
    logic [DATA_W-1:0] d;
    d = '0;
    d[HDR_SIZE_LSB +: SIZE_W]     = size;
    d[HDR_SEQ_LSB  +: SEQ_W]      = seq;
    d[HDR_FLOW_LSB +: HDR_FLOW_W] = HDR_FLOW_W'(flow);
    return d;
  endfunction

  // Each byte carries its packet offset mod 256; bytes past the packet end read 0
  function automatic logic [DATA_W-1:0] payload(input logic [SIZE_W-1:0] beat,
                                                input logic [SIZE_W-1:0] size);
    logic [DATA_W-1:0] d;
    int unsigned       off;
    d = '0;
    for (int j = 0; j < int'(BYTES_PER_WORD); j++) begin
      off = 32'(beat) * BYTES_PER_WORD + 32'(j);
      if (off < 32'(size)) d[8*j +: 8] = off[7:0];
    end
    return d;
  endfunction

  assign xfer       = out_val_o && out_ready_i;
  assign xfer_eop   = xfer && out_eop_o;
  // ready_arm_q holds task_ready_o low through reset and releases it one clock later
  assign task_ready_o = ready_arm_q && ((state_q == ST_IDLE) || xfer_eop);
  assign accept_pkt = task_valid_i && task_ready_o && (task_size_i != '0);
  assign words_new  = words_from_size(task_size_i, EMPTY_W);
  assign beat_nxt   = beat_q + SIZE_W'(1);
  // Same-flow back-to-back: the table write lands this edge, so forward the increment
  assign hdr_seq    = tbl_seq + SEQ_W'(xfer_eop && (task_flow_num_i == out_flow_num_o));

  pkt_gen_seq_tbl #(
    .FLOW_CNT (FLOW_CNT),
    .FLOW_W   (FLOW_CNT_WIDTH)
  ) u_seq_tbl (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd_flow_i  (task_flow_num_i),
    .rd_seq_c   (tbl_seq),
    .inc_i      (xfer_eop),
    .inc_flow_i (out_flow_num_o)
  );

  // Next-state and next-beat selection
  always_comb begin
    state_d = state_q;
    flow_d  = out_flow_num_o;
    size_d  = size_q;
    words_d = words_q;
    beat_d  = beat_q;
    val_d   = out_val_o;
    sop_d   = out_sop_o;
    eop_d   = out_eop_o;
    empty_d = out_empty_o;
    data_d  = out_data_o;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: load = accept_pkt;
      ST_SEND: begin
        if (xfer_eop) begin
          load = accept_pkt;
          if (!accept_pkt) begin
            state_d = ST_IDLE;
            val_d   = 1'b0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
            empty_d = '0;
            data_d  = '0;
          end
        end else if (xfer) begin
          beat_d  = beat_nxt;
          sop_d   = 1'b0;
          eop_d   = ((beat_nxt + SIZE_W'(1)) == words_q);
          empty_d = eop_d ? empty_of(size_q) : '0;
          data_d  = payload(beat_nxt, size_q);
        end
      end
      default: ;
    endcase
    if (load) begin
      state_d = ST_SEND;
      flow_d  = task_flow_num_i;
      size_d  = task_size_i;
      words_d = words_new;
      beat_d  = '0;
      val_d   = 1'b1;
      sop_d   = 1'b1;
      eop_d   = (words_new == SIZE_W'(1));
      empty_d = eop_d ? empty_of(task_size_i) : '0;
      data_d  = header(task_flow_num_i, task_size_i, hdr_seq);
    end
  end

  // State and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      ready_arm_q    <= 1'b0;
      size_q         <= '0;
      words_q        <= '0;
      beat_q         <= '0;
      out_flow_num_o <= '0;
      out_val_o      <= 1'b0;
      out_sop_o      <= 1'b0;
      out_eop_o      <= 1'b0;
      out_empty_o    <= '0;
      out_data_o     <= '0;
    end else begin
      state_q        <= state_d;
      ready_arm_q    <= 1'b1;
      size_q         <= size_d;
      words_q        <= words_d;
      beat_q         <= beat_d;
      out_flow_num_o <= flow_d;
      out_val_o      <= val_d;
      out_sop_o      <= sop_d;
      out_eop_o      <= eop_d;
      out_empty_o    <= empty_d;
      out_data_o     <= data_d;
    end
  end

  // Completed-packet counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         pkt_cnt_o <= '0;
    else if (xfer_eop) pkt_cnt_o <= pkt_cnt_o + CNT_W'(1);
  end

endmodule

// File: tb/tb_pkt_gen_ext.sv
// Self-checking bench for pkt_gen_ext with a byte-stream reference model.
module tb_pkt_gen_ext;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  task_flow_num_i;
  logic [15:0] task_size_i;
  logic        task_valid_i;
  logic        task_ready_o;
  logic [63:0] out_data_o;
  logic        out_sop_o, out_eop_o;
  logic [2:0]  out_empty_o;
  logic        out_val_o;
  logic        out_ready_i;
  logic [3:0]  out_flow_num_o;
  logic [31:0] pkt_cnt_o;

  always #5 clk_i = ~clk_i;

  pkt_gen_ext dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .task_flow_num_i (task_flow_num_i),
    .task_size_i     (task_size_i),
    .task_valid_i    (task_valid_i),
    .task_ready_o    (task_ready_o),
    .out_data_o      (out_data_o),
    .out_sop_o       (out_sop_o),
    .out_eop_o       (out_eop_o),
    .out_empty_o     (out_empty_o),
    .out_val_o       (out_val_o),
    .out_ready_i     (out_ready_i),
    .out_flow_num_o  (out_flow_num_o),
    .pkt_cnt_o       (pkt_cnt_o)
  );

  typedef struct {
    logic [63:0] data;
    bit          sop;
    bit          eop;
    int          empty;
    int          flow;
    int          cyc;
  } beat_t;

  beat_t       obs_q[$];
  beat_t       exp_q[$];
  int          tq_flow[$];
  int          tq_size[$];
  int          acc_cyc[$];
  int          checks = 0;
  int          failures = 0;
  int          stall_bad;
  bit          timed_out;
  int          ready_mode;
  int          cyc_cnt = 0;
  logic [31:0] seq_m [16];
  int unsigned pkt_m;

  always @(posedge clk_i) cyc_cnt++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int i = 0; i < 16; i++) seq_m[i] = 32'd0;
    pkt_m = 0;
  endtask

  // Builds the packet as a flat byte stream, then slices it into 8-byte beats
  task automatic model_pkt(input int flow, input int size);
    byte unsigned b[$];
    int           words;
    beat_t        bt;
    if (size == 0) return;
    words = (size + 7) / 8;
    for (int i = 0; i < words * 8; i++) b.push_back(8'((i >= 8 && i < size) ? i % 256 : 0));
    b[0] = 8'(size);
    b[1] = 8'(size >> 8);
    for (int i = 0; i < 4; i++) b[2+i] = 8'(seq_m[flow] >> (8 * i));
    b[6] = 8'(flow);
    b[7] = 8'd0;
    for (int w = 0; w < words; w++) begin
      bt.data = '0;
      for (int j = 0; j < 8; j++) bt.data[8*j +: 8] = b[w*8+j];
      bt.sop   = (w == 0);
      bt.eop   = (w == words - 1);
      bt.empty = bt.eop ? (words * 8 - size) : 0;
      bt.flow  = flow;
      bt.cyc   = 0;
      exp_q.push_back(bt);
    end
    seq_m[flow] = seq_m[flow] + 32'd1;
    pkt_m++;
  endtask

  // Presents queued tasks in order and records every transferred beat
  task automatic run_tasks();
    int          idx = 0;
    int          n;
    int          budget = 0;
    bit          acc;
    bit          prev_stall = 0;
    logic [63:0] p_data;
    logic        p_sop, p_eop;
    logic [2:0]  p_empty;
    logic [3:0]  p_flow;
    beat_t       bt;
    n = tq_flow.size();
    obs_q.delete();
    acc_cyc.delete();
    stall_bad = 0;
    timed_out = 0;
    forever begin
      @(negedge clk_i);
      task_valid_i = (idx < n);
      if (idx < n) begin
        task_flow_num_i = 4'(tq_flow[idx]);
        task_size_i     = 16'(tq_size[idx]);
      end
      case (ready_mode)
        0:       out_ready_i = 1'b1;
        1:       out_ready_i = (budget % 5 == 0) || (budget % 5 == 3);
        default: out_ready_i = 1'($urandom_range(0, 1));
      endcase
      #2;
      if (prev_stall && (out_data_o !== p_data || out_sop_o !== p_sop || out_eop_o !== p_eop ||
                         out_empty_o !== p_empty || out_flow_num_o !== p_flow || out_val_o !== 1'b1))
        stall_bad++;
      acc = task_valid_i && task_ready_o;
      if (out_val_o && out_ready_i) begin
        bt.data  = out_data_o;
        bt.sop   = out_sop_o;
        bt.eop   = out_eop_o;
        bt.empty = int'(out_empty_o);
        bt.flow  = int'(out_flow_num_o);
        bt.cyc   = cyc_cnt;
        obs_q.push_back(bt);
      end
      if (acc) begin
        acc_cyc.push_back(cyc_cnt);
        idx++;
      end
      prev_stall = out_val_o && !out_ready_i;
      p_data  = out_data_o;
      p_sop   = out_sop_o;
      p_eop   = out_eop_o;
      p_empty = out_empty_o;
      p_flow  = out_flow_num_o;
      budget++;
      if (!acc && idx >= n && !out_val_o) break;
      if (budget > 40000) begin
        timed_out = 1;
        break;
      end
    end
    task_valid_i = 1'b0;
    tq_flow.delete();
    tq_size.delete();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    task_valid_i = 1'b0;
    task_flow_num_i = 4'd0;
    task_size_i = 16'd0;
    out_ready_i = 1'b0;
    ready_mode = 0;
    repeat (3) @(negedge clk_i);
    #1;
    checks++;
    if ({out_val_o, out_sop_o, out_eop_o, task_ready_o, out_empty_o, out_flow_num_o, out_data_o, pkt_cnt_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: val=%b sop=%b eop=%b rdy=%b empty=%0d flow=%0d data=%h cnt=%0d, want all 0",
               out_val_o, out_sop_o, out_eop_o, task_ready_o, out_empty_o, out_flow_num_o, out_data_o, pkt_cnt_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    checks++;
    if (task_ready_o !== 1'b1 || out_val_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: task_ready=%b val=%b, want 1 0", task_ready_o, out_val_o);
    end
    model_reset();
  endtask

  task automatic test_basic();
    int eops = 0;
    tq_flow.push_back(3); tq_size.push_back(64); model_pkt(3, 64);
    ready_mode = 0;
    run_tasks();
    exp_q.delete();
    checks++;
    if (timed_out || obs_q.size() != 8) begin
      failures++;
      $display("FAIL basic_beats: got %0d beats (timeout=%0d), want 8", obs_q.size(), timed_out);
    end
    foreach (obs_q[i]) if (obs_q[i].eop) eops++;
    checks++;
    if (obs_q[0].sop !== 1'b1 || obs_q[7].eop !== 1'b1 || eops != 1 || obs_q[7].empty != 0) begin
      failures++;
      $display("FAIL basic_framing: sop0=%b eop7=%b eops=%0d empty=%0d, want 1 1 1 0",
               obs_q[0].sop, obs_q[7].eop, eops, obs_q[7].empty);
    end
    checks++;
    if (obs_q[0].data !== 64'h0003_0000_0000_0040) begin
      failures++;
      $display("FAIL basic_header: got %h, want 0003000000000040", obs_q[0].data);
    end
    checks++;
    if (obs_q[1].data !== 64'h0f0e_0d0c_0b0a_0908) begin
      failures++;
      $display("FAIL basic_beat1: got %h, want 0f0e0d0c0b0a0908", obs_q[1].data);
    end
    checks++;
    if (pkt_cnt_o !== 32'd1) begin
      failures++;
      $display("FAIL basic_pkt_cnt: got %0d, want 1", pkt_cnt_o);
    end
  endtask

  task automatic test_sizes();
    tq_flow.push_back(1); tq_size.push_back(65); model_pkt(1, 65);
    tq_flow.push_back(1); tq_size.push_back(1);  model_pkt(1, 1);
    ready_mode = 0;
    run_tasks();
    exp_q.delete();
    checks++;
    if (obs_q.size() != 10) begin
      failures++;
      $display("FAIL sizes_beats: got %0d, want 10", obs_q.size());
    end
    checks++;
    if (obs_q[8].eop !== 1'b1 || obs_q[8].empty != 7 || obs_q[8].data !== 64'h40) begin
      failures++;
      $display("FAIL size65_last: eop=%b empty=%0d data=%h, want 1 7 0000000000000040",
               obs_q[8].eop, obs_q[8].empty, obs_q[8].data);
    end
    checks++;
    if (obs_q[9].sop !== 1'b1 || obs_q[9].eop !== 1'b1 || obs_q[9].empty != 7 ||
        obs_q[9].data !== 64'h0001_0000_0001_0001) begin
      failures++;
      $display("FAIL size1_beat: sop=%b eop=%b empty=%0d data=%h, want 1 1 7 0001000000010001",
               obs_q[9].sop, obs_q[9].eop, obs_q[9].empty, obs_q[9].data);
    end
  endtask

  task automatic test_stall();
    int cnt0;
    cnt0 = int'(pkt_cnt_o);
    tq_flow.push_back(0); tq_size.push_back(40); model_pkt(0, 40);
    ready_mode = 1;
    run_tasks();
    checks++;
    if (obs_q.size() != 5 || stall_bad != 0) begin
      failures++;
      $display("FAIL stall_transfers: got %0d beats with %0d unstable stalls, want 5 and 0", obs_q.size(), stall_bad);
    end
    checks++;
    if (int'(pkt_cnt_o) != cnt0 + 1) begin
      failures++;
      $display("FAIL stall_pkt_cnt: got %0d, want %0d", pkt_cnt_o, cnt0 + 1);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].sop != exp_q[i].sop || obs_q[i].eop != exp_q[i].eop ||
          obs_q[i].empty != exp_q[i].empty || obs_q[i].flow != exp_q[i].flow) begin
        failures++;
        $display("FAIL stall_beat%0d: got %h/%b/%b/%0d/%0d, want %h/%b/%b/%0d/%0d", i,
                 obs_q[i].data, obs_q[i].sop, obs_q[i].eop, obs_q[i].empty, obs_q[i].flow,
                 exp_q[i].data, exp_q[i].sop, exp_q[i].eop, exp_q[i].empty, exp_q[i].flow);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    tq_flow.push_back(2); tq_size.push_back(16); model_pkt(2, 16);
    tq_flow.push_back(2); tq_size.push_back(24); model_pkt(2, 24);
    ready_mode = 0;
    run_tasks();
    checks++;
    if (obs_q.size() != 5 || acc_cyc.size() != 2) begin
      failures++;
      $display("FAIL b2b_counts: beats=%0d accepts=%0d, want 5 2", obs_q.size(), acc_cyc.size());
    end
    checks++;
    if (obs_q[1].eop !== 1'b1 || acc_cyc[1] != obs_q[1].cyc) begin
      failures++;
      $display("FAIL b2b_ready_on_eop: eop=%b accept_cyc=%0d eop_cyc=%0d, want eop 1 and equal cycles",
               obs_q[1].eop, acc_cyc[1], obs_q[1].cyc);
    end
    checks++;
    if (obs_q[2].sop !== 1'b1 || obs_q[2].cyc != obs_q[1].cyc + 1) begin
      failures++;
      $display("FAIL b2b_no_gap: sop=%b cyc=%0d, want sop 1 at cyc %0d", obs_q[2].sop, obs_q[2].cyc, obs_q[1].cyc + 1);
    end
    checks++;
    if (obs_q[2].data[47:16] !== 32'd1) begin
      failures++;
      $display("FAIL b2b_seq: got %0d, want 1", obs_q[2].data[47:16]);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].sop != exp_q[i].sop || obs_q[i].eop != exp_q[i].eop ||
          obs_q[i].empty != exp_q[i].empty || obs_q[i].flow != exp_q[i].flow) begin
        failures++;
        $display("FAIL b2b_beat%0d: got %h/%b/%b/%0d/%0d, want %h/%b/%b/%0d/%0d", i,
                 obs_q[i].data, obs_q[i].sop, obs_q[i].eop, obs_q[i].empty, obs_q[i].flow,
                 exp_q[i].data, exp_q[i].sop, exp_q[i].eop, exp_q[i].empty, exp_q[i].flow);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    int f, s, r;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin
        for (int k = 0; k < 12; k++) begin
          f = int'($urandom_range(0, 15));
          r = int'($urandom_range(0, 9));
          s = (r == 0) ? 0 : (r < 7) ? int'($urandom_range(1, 80)) : int'($urandom_range(81, 400));
          tq_flow.push_back(f); tq_size.push_back(s); model_pkt(f, s);
        end
        ready_mode = 2;
      end else begin
        tq_flow.push_back(7); tq_size.push_back(65535); model_pkt(7, 65535);
        ready_mode = 0;
      end
      run_tasks();
      checks++;
      if (timed_out || obs_q.size() != exp_q.size() || stall_bad != 0) begin
        failures++;
        $display("FAIL random%0d_stream: beats=%0d want %0d, timeout=%0d unstable_stalls=%0d",
                 pass, obs_q.size(), exp_q.size(), timed_out, stall_bad);
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i].data !== exp_q[i].data || obs_q[i].sop != exp_q[i].sop || obs_q[i].eop != exp_q[i].eop ||
            obs_q[i].empty != exp_q[i].empty || obs_q[i].flow != exp_q[i].flow) begin
          failures++;
          $display("FAIL random%0d_beat%0d: got %h/%b/%b/%0d/%0d, want %h/%b/%b/%0d/%0d", pass, i,
                   obs_q[i].data, obs_q[i].sop, obs_q[i].eop, obs_q[i].empty, obs_q[i].flow,
                   exp_q[i].data, exp_q[i].sop, exp_q[i].eop, exp_q[i].empty, exp_q[i].flow);
        end
      end
      exp_q.delete();
      checks++;
      if (pkt_cnt_o !== 32'(pkt_m)) begin
        failures++;
        $display("FAIL random%0d_pkt_cnt: got %0d, want %0d", pass, pkt_cnt_o, pkt_m);
      end
    end
  endtask

  task automatic test_zero_and_reset();
    int  n = 0;
    bit  seen_acc = 0;
    tq_flow.push_back(5); tq_size.push_back(0); model_pkt(5, 0);
    ready_mode = 0;
    run_tasks();
    checks++;
    if (acc_cyc.size() != 1 || obs_q.size() != 0 || pkt_cnt_o !== 32'(pkt_m) || task_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL zero_size: accepts=%0d beats=%0d cnt=%0d ready=%b, want 1 0 %0d 1",
               acc_cyc.size(), obs_q.size(), pkt_cnt_o, task_ready_o, pkt_m);
    end
    // Start a 64-byte packet on flow 5 and reset while beat 3 is on the bus
    @(negedge clk_i);
    task_valid_i = 1'b1; task_flow_num_i = 4'd5; task_size_i = 16'd64; out_ready_i = 1'b1;
    for (int c = 0; c < 10 && !seen_acc; c++) begin
      #2;
      seen_acc = task_ready_o;
      @(negedge clk_i);
    end
    task_valid_i = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #2;
      if (out_val_o) begin
        if (n == 3) break;
        n++;
      end
      @(negedge clk_i);
    end
    checks++;
    if (!seen_acc || n != 3 || out_val_o !== 1'b1 || pkt_cnt_o !== 32'(pkt_m)) begin
      failures++;
      $display("FAIL reset_setup: accepted=%0d beats=%0d val=%b cnt=%0d, want 1 3 1 %0d",
               seen_acc, n, out_val_o, pkt_cnt_o, pkt_m);
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if (out_val_o !== 1'b0 || out_eop_o !== 1'b0 || pkt_cnt_o !== 32'd0 || task_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_midpkt: val=%b eop=%b cnt=%0d ready=%b, want 0 0 0 0",
               out_val_o, out_eop_o, pkt_cnt_o, task_ready_o);
    end
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    tq_flow.push_back(5); tq_size.push_back(16); model_pkt(5, 16);
    run_tasks();
    checks++;
    if (obs_q.size() != 2 || obs_q[0].data !== 64'h0005_0000_0000_0010 || obs_q[1].data !== 64'h0f0e_0d0c_0b0a_0908) begin
      failures++;
      $display("FAIL post_reset_pkt: beats=%0d hdr=%h b1=%h, want 2 0005000000000010 0f0e0d0c0b0a0908",
               obs_q.size(), obs_q[0].data, obs_q[1].data);
    end
    checks++;
    if (pkt_cnt_o !== 32'd1) begin
      failures++;
      $display("FAIL post_reset_cnt: got %0d, want 1", pkt_cnt_o);
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sizes();
    test_stall();
    test_back_to_back();
    test_random();
    test_zero_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
